// File: rtl/striping_pkg.sv
// Shared types and sizing helpers for the two-lane striping scheduler.
package striping_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int DATA_W_DEF = 32;
   localparam int STALL_W    = 16;

   function automatic int credit_w(input int credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/lane_credit_cnt.sv
// Per-lane downstream credit counter; a return at full credit is dropped and flagged.
module lane_credit_cnt
   import striping_pkg::*;
#(
   parameter int CREDITS = 4,
   parameter int CW      = credit_w(CREDITS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          consume_i,
   input  logic          ret_i,
   output logic [CW-1:0] count_o,
   output logic          has_credit_o,
   output logic          full_o,
   output logic          overflow_err_o
);

   localparam logic [CW-1:0] FULL_VAL = CW'(CREDITS);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          overflow_s;

   // Next count: consume and return together cancel out.
   always_comb begin
      count_d    = count_q;
      overflow_s = 1'b0;
      if (consume_i && !ret_i) begin
         if (count_q != '0) begin
            count_d = count_q - CW'(1);
         end else begin
            count_d = count_q;
         end
      end else if (ret_i && !consume_i) begin
         if (count_q == FULL_VAL) begin
            overflow_s = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else begin
         count_d = count_q;
      end
   end

   // Credit count register, starts full.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= FULL_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o        = count_q;
   assign has_credit_o   = (count_q != '0);
   assign full_o         = (count_q == FULL_VAL);
   assign overflow_err_o = overflow_s;

endmodule

// File: rtl/striping_ctrl.sv
// Credit-based round-robin scheduler feeding two striping lanes, with
// enable/drain sequencing and stall statistics.
module striping_ctrl
   import striping_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CREDITS = 4
) (
   input  logic               clk_2f,
   input  logic               reset,
   input  logic               enable,
   input  logic               valid_in,
   input  logic [DATA_W-1:0]  data_in,
   output logic               ready_out,
   output logic [DATA_W-1:0]  lane_0,
   output logic [DATA_W-1:0]  lane_1,
   output logic               valid_0,
   output logic               valid_1,
   input  logic               credit_ret_0,
   input  logic               credit_ret_1,
   output logic               cur_lane,
   output logic               idle,
   output logic [STALL_W-1:0] stall_cnt,
   output logic               credit_err
);

   localparam int CW = credit_w(CREDITS);

   state_e              state_q, state_d;
   logic                cur_lane_q, cur_lane_d;
   logic [DATA_W-1:0]   lane_0_q, lane_0_d, lane_1_q, lane_1_d;
   logic                valid_0_q, valid_0_d, valid_1_q, valid_1_d;
   logic [STALL_W-1:0]  stall_q, stall_d;
   logic                err_q, err_d;

   logic                ready_s, accept_s, consume_0_s, consume_1_s;
   logic [CW-1:0]       count_0_s, count_1_s;
   logic                has_0_s, has_1_s, full_0_s, full_1_s, ovf_0_s, ovf_1_s;
   logic                unused_counts_s;

   lane_credit_cnt #(.CREDITS(CREDITS), .CW(CW)) u_credit_0 (
      .clk_i(clk_2f), .rst_i(reset), .consume_i(consume_0_s), .ret_i(credit_ret_0),
      .count_o(count_0_s), .has_credit_o(has_0_s), .full_o(full_0_s), .overflow_err_o(ovf_0_s)
   );

   lane_credit_cnt #(.CREDITS(CREDITS), .CW(CW)) u_credit_1 (
      .clk_i(clk_2f), .rst_i(reset), .consume_i(consume_1_s), .ret_i(credit_ret_1),
      .count_o(count_1_s), .has_credit_o(has_1_s), .full_o(full_1_s), .overflow_err_o(ovf_1_s)
   );

   assign unused_counts_s = ^{count_0_s, count_1_s};

   // Handshake and next-state logic; ready depends on registers only, never on valid_in.
   always_comb begin
      ready_s     = (state_q == RUN) && (cur_lane_q ? has_1_s : has_0_s);
      accept_s    = valid_in && ready_s;
      consume_0_s = accept_s && !cur_lane_q;
      consume_1_s = accept_s && cur_lane_q;

      state_d = state_q;
      case (state_q)
         IDLE:    state_d = enable ? RUN : IDLE;
         RUN:     state_d = enable ? RUN : DRAIN;
         DRAIN:   state_d = (full_0_s && full_1_s) ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase

      if ((state_q == DRAIN) && (state_d == IDLE)) begin
         cur_lane_d = 1'b0;
      end else if (accept_s) begin
         cur_lane_d = !cur_lane_q;
      end else begin
         cur_lane_d = cur_lane_q;
      end

      valid_0_d = consume_0_s;
      valid_1_d = consume_1_s;
      lane_0_d  = consume_0_s ? data_in : lane_0_q;
      lane_1_d  = consume_1_s ? data_in : lane_1_q;

      if ((state_q != IDLE) && valid_in && !ready_s && (stall_q != {STALL_W{1'b1}})) begin
         stall_d = stall_q + STALL_W'(1);
      end else begin
         stall_d = stall_q;
      end

      err_d = err_q || ovf_0_s || ovf_1_s;
   end

   // State, lane pointer, lane outputs and statistics registers.
   always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_lane_q <= 1'b0;
         lane_0_q   <= '0;
         lane_1_q   <= '0;
         valid_0_q  <= 1'b0;
         valid_1_q  <= 1'b0;
         stall_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_lane_q <= cur_lane_d;
         lane_0_q   <= lane_0_d;
         lane_1_q   <= lane_1_d;
         valid_0_q  <= valid_0_d;
         valid_1_q  <= valid_1_d;
         stall_q    <= stall_d;
         err_q      <= err_d;
      end
   end

   assign ready_out  = ready_s;
   assign lane_0     = lane_0_q;
   assign lane_1     = lane_1_q;
   assign valid_0    = valid_0_q;
   assign valid_1    = valid_1_q;
   assign cur_lane   = cur_lane_q;
   assign idle       = (state_q == IDLE);
   assign stall_cnt  = stall_q;
   assign credit_err = err_q;

endmodule

// File: tb/tb_striping_ctrl.sv
// Directed self-checking bench for striping_ctrl with CREDITS=4.
module tb_striping_ctrl;

   logic        clk_2f = 1'b0;
   logic        reset, enable, valid_in, credit_ret_0, credit_ret_1;
   logic [31:0] data_in;
   logic        ready_out, valid_0, valid_1, cur_lane, idle, credit_err;
   logic [31:0] lane_0, lane_1;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   striping_ctrl #(.DATA_W(32), .CREDITS(4)) dut (
      .clk_2f(clk_2f), .reset(reset), .enable(enable), .valid_in(valid_in),
      .data_in(data_in), .ready_out(ready_out), .lane_0(lane_0), .lane_1(lane_1),
      .valid_0(valid_0), .valid_1(valid_1), .credit_ret_0(credit_ret_0),
      .credit_ret_1(credit_ret_1), .cur_lane(cur_lane), .idle(idle),
      .stall_cnt(stall_cnt), .credit_err(credit_err)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic step();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 32'h0;
      credit_ret_0 = 1'b0; credit_ret_1 = 1'b0;
      #3;
      total++;
      if ({ready_out, idle, cur_lane, valid_0, valid_1, credit_err} !== 6'b010000) begin
         $display("FAIL reset_flags got=%b exp=%b", {ready_out, idle, cur_lane, valid_0, valid_1, credit_err}, 6'b010000); bad++;
      end
      total++;
      if ({lane_0, lane_1, stall_cnt} !== 80'h0) begin
         $display("FAIL reset_data got=%h exp=0", {lane_0, lane_1, stall_cnt}); bad++;
      end
      @(negedge clk_2f);
      reset = 1'b0;
   endtask

   task automatic test_stream();
      enable = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         valid_in = 1'b1; data_in = 32'(i);
         total++;
         if (ready_out !== 1'b1) begin $display("FAIL stream_ready[%0d] got=%b exp=1", i, ready_out); bad++; end
         step();
         total++;
         if (i % 2 == 0) begin
            if ({valid_0, valid_1} !== 2'b10 || lane_0 !== 32'(i)) begin
               $display("FAIL stream_lane0[%0d] got v=%b%b d=%h exp v=10 d=%h", i, valid_0, valid_1, lane_0, i); bad++;
            end
         end else begin
            if ({valid_0, valid_1} !== 2'b01 || lane_1 !== 32'(i)) begin
               $display("FAIL stream_lane1[%0d] got v=%b%b d=%h exp v=01 d=%h", i, valid_0, valid_1, lane_1, i); bad++;
            end
         end
      end
      data_in = 32'h8;
      total++;
      if (ready_out !== 1'b0) begin $display("FAIL stream_exhaust got=%b exp=0", ready_out); bad++; end
      total++;
      if (stall_cnt !== 16'd0) begin $display("FAIL stream_stall got=%0d exp=0", stall_cnt); bad++; end
   endtask

   task automatic test_stall_return();
      for (int k = 0; k < 4; k++) begin
         step();
         total++;
         if (ready_out !== 1'b0) begin $display("FAIL stall_ready[%0d] got=%b exp=0", k, ready_out); bad++; end
      end
      credit_ret_0 = 1'b1;
      total++;
      if (ready_out !== 1'b0) begin $display("FAIL ret_same_cycle got=%b exp=0", ready_out); bad++; end
      step();
      credit_ret_0 = 1'b0;
      total++;
      if ({ready_out, cur_lane} !== 2'b10 || stall_cnt !== 16'd5) begin
         $display("FAIL stall_release got rdy=%b lane=%b stall=%0d exp rdy=1 lane=0 stall=5", ready_out, cur_lane, stall_cnt); bad++;
      end
      step();
      valid_in = 1'b0;
      total++;
      if ({valid_0, valid_1} !== 2'b10 || lane_0 !== 32'h8 || lane_1 !== 32'h7) begin
         $display("FAIL word8 got v=%b%b l0=%h l1=%h exp v=10 l0=8 l1=7", valid_0, valid_1, lane_0, lane_1); bad++;
      end
   endtask

   task automatic test_no_skip();
      credit_ret_0 = 1'b1;
      step(); step();
      credit_ret_0 = 1'b0;
      valid_in = 1'b1; data_in = 32'h9;
      total++;
      if ({ready_out, cur_lane} !== 2'b01) begin
         $display("FAIL no_skip got rdy=%b lane=%b exp rdy=0 lane=1", ready_out, cur_lane); bad++;
      end
      step();
      credit_ret_1 = 1'b1;
      step();
      credit_ret_1 = 1'b0;
      total++;
      if (ready_out !== 1'b1) begin $display("FAIL lane1_release got=%b exp=1", ready_out); bad++; end
      step();
      valid_in = 1'b0;
      total++;
      if ({valid_0, valid_1} !== 2'b01 || lane_1 !== 32'h9 || stall_cnt !== 16'd7) begin
         $display("FAIL word9 got v=%b%b l1=%h stall=%0d exp v=01 l1=9 stall=7", valid_0, valid_1, lane_1, stall_cnt); bad++;
      end
   endtask

   task automatic test_full_rate();
      credit_ret_1 = 1'b1;
      step();
      credit_ret_1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         valid_in = 1'b1; data_in = 32'h100 + 32'(i);
         credit_ret_0 = (i % 2 == 0); credit_ret_1 = (i % 2 == 1);
         total++;
         if (ready_out !== 1'b1) begin $display("FAIL full_rate_ready[%0d] got=%b exp=1", i, ready_out); bad++; end
         step();
         total++;
         if ((i % 2 == 0) ? (valid_0 !== 1'b1 || lane_0 !== 32'h100 + 32'(i))
                          : (valid_1 !== 1'b1 || lane_1 !== 32'h100 + 32'(i))) begin
            $display("FAIL full_rate_data[%0d] got l0=%h l1=%h v=%b%b exp %h", i, lane_0, lane_1, valid_0, valid_1, 32'h100 + 32'(i)); bad++;
         end
      end
      valid_in = 1'b0; credit_ret_0 = 1'b0; credit_ret_1 = 1'b0;
      total++;
      if (stall_cnt !== 16'd7) begin $display("FAIL full_rate_stall got=%0d exp=7", stall_cnt); bad++; end
   endtask

   task automatic test_drain();
      credit_ret_0 = 1'b1; credit_ret_1 = 1'b1;
      step();
      credit_ret_1 = 1'b0;
      step();
      credit_ret_0 = 1'b0;
      valid_in = 1'b1; data_in = 32'h200;
      step();
      valid_in = 1'b0;
      total++;
      if (valid_0 !== 1'b1 || lane_0 !== 32'h200) begin $display("FAIL pre_drain got v0=%b l0=%h exp v0=1 l0=200", valid_0, lane_0); bad++; end
      enable = 1'b0;
      step();
      total++;
      if ({idle, ready_out, cur_lane} !== 3'b001) begin
         $display("FAIL drain_entry got idle=%b rdy=%b lane=%b exp 0 0 1", idle, ready_out, cur_lane); bad++;
      end
      enable = 1'b1;
      step();
      total++;
      if ({idle, ready_out} !== 2'b00) begin $display("FAIL drain_ignore_en got idle=%b rdy=%b exp 0 0", idle, ready_out); bad++; end
      credit_ret_1 = 1'b1; step(); credit_ret_1 = 1'b0;
      credit_ret_0 = 1'b1; step(); credit_ret_0 = 1'b0;
      total++;
      if (idle !== 1'b0) begin $display("FAIL drain_hold got idle=%b exp 0", idle); bad++; end
      credit_ret_1 = 1'b1; step(); credit_ret_1 = 1'b0;
      step();
      total++;
      if ({idle, cur_lane, ready_out} !== 3'b100) begin
         $display("FAIL drain_exit got idle=%b lane=%b rdy=%b exp 1 0 0", idle, cur_lane, ready_out); bad++;
      end
      step();
      total++;
      if ({idle, ready_out, cur_lane} !== 3'b010) begin
         $display("FAIL reenable got idle=%b rdy=%b lane=%b exp 0 1 0", idle, ready_out, cur_lane); bad++;
      end
      valid_in = 1'b1; data_in = 32'h300;
      step();
      valid_in = 1'b0;
      total++;
      if ({valid_0, valid_1} !== 2'b10 || lane_0 !== 32'h300 || stall_cnt !== 16'd7) begin
         $display("FAIL first_after_drain got v=%b%b l0=%h stall=%0d exp v=10 l0=300 stall=7", valid_0, valid_1, lane_0, stall_cnt); bad++;
      end
   endtask

   task automatic test_credit_err_reset();
      credit_ret_0 = 1'b1; credit_ret_1 = 1'b1;
      step();
      credit_ret_0 = 1'b0; credit_ret_1 = 1'b0;
      total++;
      if (credit_err !== 1'b1) begin $display("FAIL credit_err_set got=%b exp=1", credit_err); bad++; end
      step();
      total++;
      if (credit_err !== 1'b1) begin $display("FAIL credit_err_sticky got=%b exp=1", credit_err); bad++; end
      for (int i = 0; i < 8; i++) begin
         valid_in = 1'b1; data_in = 32'h400 + 32'(i);
         total++;
         if (ready_out !== 1'b1) begin $display("FAIL err_stream_ready[%0d] got=%b exp=1", i, ready_out); bad++; end
         step();
         total++;
         if ((i % 2 == 0) ? (valid_1 !== 1'b1 || lane_1 !== 32'h400 + 32'(i))
                          : (valid_0 !== 1'b1 || lane_0 !== 32'h400 + 32'(i))) begin
            $display("FAIL err_stream_data[%0d] got l0=%h l1=%h v=%b%b exp %h", i, lane_0, lane_1, valid_0, valid_1, 32'h400 + 32'(i)); bad++;
         end
      end
      total++;
      if ({ready_out, cur_lane} !== 2'b01) begin
         $display("FAIL err_count_full got rdy=%b lane=%b exp rdy=0 lane=1", ready_out, cur_lane); bad++;
      end
      reset = 1'b1;
      #1;
      total++;
      if ({ready_out, idle, cur_lane, valid_0, valid_1, credit_err} !== 6'b010000 || {lane_0, lane_1, stall_cnt} !== 80'h0) begin
         $display("FAIL async_reset got flags=%b data=%h exp flags=010000 data=0",
                  {ready_out, idle, cur_lane, valid_0, valid_1, credit_err}, {lane_0, lane_1, stall_cnt}); bad++;
      end
      @(negedge clk_2f);
      reset = 1'b0;
      data_in = 32'h500;
      step();
      total++;
      if ({ready_out, cur_lane} !== 2'b10) begin $display("FAIL post_reset_ready got rdy=%b lane=%b exp 1 0", ready_out, cur_lane); bad++; end
      step();
      valid_in = 1'b0;
      total++;
      if ({valid_0, valid_1} !== 2'b10 || lane_0 !== 32'h500 || lane_1 !== 32'h0) begin
         $display("FAIL post_reset_word got v=%b%b l0=%h l1=%h exp v=10 l0=500 l1=0", valid_0, valid_1, lane_0, lane_1); bad++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_return();
      test_no_skip();
      test_full_rate();
      test_drain();
      test_credit_err_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/striping_ctrl.md
# striping_ctrl

Credit-based scheduler that feeds the two-lane striping datapath at clk_2f. Accepts a 32-bit word stream with a valid/ready handshake, assigns words alternately to lane 0 and lane 1, and stalls whenever the lane whose turn it is has no downstream credit. This preserves strict round-robin order for the unstriping side. It also provides controlled enable/drain sequencing and stall statistics.

## Interface
- DATA_W, 32, word width of data_in and both lanes
- CREDITS, 4, per-lane credit count (downstream buffer depth), range 1..15
- clk_2f  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- enable  input  1  level; 1 = run, 0 = stop accepting and drain
- valid_in  input  1  upstream word valid
- data_in  input  DATA_W  upstream word
- ready_out  output  1  upstream handshake; a word transfers when valid_in & ready_out
- lane_0 / lane_1  output  DATA_W  registered lane data
- valid_0 / valid_1  output  1  registered lane valid, one-cycle pulse per word
- credit_ret_0 / credit_ret_1  input  1  one-cycle pulse; downstream freed one slot
- cur_lane  output  1  lane that receives the next accepted word
- idle  output  1  1 in IDLE state
- stall_cnt  output  16  count of cycles with valid_in & !ready_out, saturating
- credit_err  output  1  sticky; set by a credit return to a lane already at CREDITS

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: ready_out=0. Moves to RUN when enable=1.
- RUN: ready_out = credit[cur_lane] != 0 (combinational from registers only, never from valid_in). Moves to DRAIN when enable=0.
- DRAIN: ready_out=0. Moves to IDLE when both credit counters equal CREDITS. enable=1 during DRAIN is ignored until IDLE is reached. On entry to IDLE, cur_lane is forced to 0.
- Accept in RUN:
  - data_in is registered onto lane[cur_lane], and valid[cur_lane] pulses the next cycle.
  - credit[cur_lane] decrements by 1.
  - cur_lane toggles.
- The non-selected lane's data holds its value, and its valid is 0.
- Credit counters are ceil(log2(CREDITS+1)) bits wide.
  - A return pulse and a consume on the same lane in the same cycle leave the count unchanged.
  - A return at CREDITS is dropped, the count stays at CREDITS, and credit_err is set.
  - Returns are honoured in every state.
- stall_cnt increments in RUN or DRAIN whenever valid_in=1 and ready_out=0. It saturates at 16'hFFFF and never wraps.
- No word is ever dropped. Word order on the lanes is always: first accepted word on lane 0, then alternating.

## Timing
- Reset values:
  - FSM = IDLE, cur_lane = 0, idle = 1
  - both credits = CREDITS
  - lane_0 = lane_1 = 0, valid_0 = valid_1 = 0
  - ready_out = 0, stall_cnt = 0, credit_err = 0
- Latency: accept in cycle N → lane data/valid visible after edge N+1 (1 cycle).
- Throughput: one word per clk_2f while credits allow, so each lane gets one word per two cycles.
- A credit returned in cycle N can enable ready_out in cycle N+1, not in cycle N.
- IDLE→RUN: ready_out may be asserted in the cycle after enable is sampled high.
- enable falling: the last acceptance is in the cycle where enable is sampled low; the FSM is in DRAIN the following cycle.
- Reset asserted mid-burst: all outputs take their reset values immediately (asynchronous). In-flight words are discarded, and credits are restored to CREDITS.

## Structure
- Shared package striping_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - DATA_W default
  - STALL_W=16
  - credit-width function
- One sub-module, lane_credit_cnt, instantiated twice:
  - inputs: consume, ret
  - outputs: count, has_credit, full, overflow_err
- FSM, lane pointer, output registers and stall counter stay in striping_ctrl.

## Test plan
- Reset, enable=1, stream 8 words 0x0..0x7 with no credit returns (CREDITS=4) → lane_0 gets 0,2,4,6 and lane_1 gets 1,3,5,7, each one cycle after acceptance. ready_out drops after the 8th word; stall_cnt=0.
- Continue from the previous test holding valid_in=1 for 5 stalled cycles, then a return on lane 0 only → next word 0x8 goes to lane 0 one cycle after the return. stall_cnt=5.
- Exhaust lane 1 credits only; cur_lane=1 with lane 0 credits available → ready_out=0 (no lane skipping). A return on lane 1 releases the next word onto lane 1.
- Simultaneous consume and return on the same lane for 20 cycles at full rate → credit count is constant and no stall occurs.
- enable=0 with 3 credits outstanding → FSM holds DRAIN and idle=0. After the 3rd return, idle=1 and cur_lane=0. Re-enable, and the first word lands on lane 0.
- Extra return on a full lane → credit_err=1 and stays set, count remains CREDITS. Assert reset mid-stream → all outputs return to reset values.
